// File: rtl/wave_protocol_checker.sv
// wave_protocol_checker: samples sig1/sig2/sig3 from the waveform generator
// over a fixed RUN window and reports toggle counts, the first sig3 pulse
// width and a single pass/fail verdict with sticky per-check error bits.
module wave_protocol_checker #(
  parameter int unsigned EXP_TOGGLES = 10,
  parameter int unsigned WINDOW      = 16,
  parameter int unsigned SIG3_MIN    = 2,
  parameter int unsigned SIG3_MAX    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sig1,
  input  logic       sig2,
  input  logic       sig3,
  output logic [7:0] tog1_cnt,
  output logic [7:0] tog2_cnt,
  output logic [7:0] sig3_width,
  output logic [3:0] err,
  output logic       done,
  output logic       pass
);

  localparam int unsigned CW = 8;
  localparam int unsigned PW = 2;
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] WIN_LAST = CW'(WINDOW - 1);
  localparam logic [CW-1:0] EXP_TOG  = CW'(EXP_TOGGLES);
  localparam logic [CW-1:0] WID_MIN  = CW'(SIG3_MIN);
  localparam logic [CW-1:0] WID_MAX  = CW'(SIG3_MAX);
  localparam logic [PW-1:0] PULSE_MAX = '1;

  typedef enum logic [1:0] {
    ST_ARM   = 2'd0,
    ST_RUN   = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t          state;
  logic [CW-1:0]   win_cnt;
  logic [PW-1:0]   pulse_cnt;
  logic            p1;
  logic            p2;
  logic            p3;

  logic            sig3_rise_c;
  logic [PW-1:0]   pulse_nxt_c;
  logic [3:0]      chk_err_c;

  // Next pulse count (includes this cycle's rising edge) and verdict error bits
  always_comb begin
    sig3_rise_c = sig3 & ~p3;
    pulse_nxt_c = pulse_cnt;
    if (sig3_rise_c && (pulse_cnt != PULSE_MAX)) begin
      pulse_nxt_c = pulse_cnt + PW'(1);
    end

    chk_err_c = err;
    if (tog1_cnt != EXP_TOG) begin
      chk_err_c[1] = 1'b1;
    end
    if (tog2_cnt != EXP_TOG) begin
      chk_err_c[2] = 1'b1;
    end
    if ((pulse_cnt != PW'(1)) || (sig3_width < WID_MIN) ||
        (sig3_width > WID_MAX) || p3) begin
      chk_err_c[3] = 1'b1;
    end
  end

  // Observation FSM: arm on initial levels, count over the window, then judge once
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_ARM;
      win_cnt    <= '0;
      pulse_cnt  <= '0;
      p1         <= 1'b0;
      p2         <= 1'b1;
      p3         <= 1'b0;
      tog1_cnt   <= '0;
      tog2_cnt   <= '0;
      sig3_width <= '0;
      err        <= '0;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else begin
      case (state)
        ST_ARM: begin
          p1 <= sig1;
          p2 <= sig2;
          p3 <= sig3;
          if (sig1 || !sig2 || sig3) begin
            err[0] <= 1'b1;
          end
          state <= ST_RUN;
        end

        ST_RUN: begin
          if ((sig1 != p1) && (tog1_cnt != CNT_MAX)) begin
            tog1_cnt <= tog1_cnt + CW'(1);
          end
          if ((sig2 != p2) && (tog2_cnt != CNT_MAX)) begin
            tog2_cnt <= tog2_cnt + CW'(1);
          end
          pulse_cnt <= pulse_nxt_c;
          // Width only accumulates for the first pulse
          if (sig3 && (pulse_nxt_c <= PW'(1)) && (sig3_width != CNT_MAX)) begin
            sig3_width <= sig3_width + CW'(1);
          end
          p1      <= sig1;
          p2      <= sig2;
          p3      <= sig3;
          win_cnt <= win_cnt + CW'(1);
          if (win_cnt == WIN_LAST) begin
            state <= ST_CHECK;
          end
        end

        ST_CHECK: begin
          err   <= chk_err_c;
          done  <= 1'b1;
          pass  <= (chk_err_c == 4'd0);
          state <= ST_DONE;
        end

        ST_DONE: begin
          state <= ST_DONE;
        end

        default: begin
          state <= ST_ARM;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wave_protocol_checker.sv
// tb_wave_protocol_checker: directed and randomized sample sequences driven into
// two checker instances (WINDOW=16 and WINDOW=255), compared to a sample-level model.
module tb_wave_protocol_checker;

  localparam int NS    = 260;
  localparam int WIN_A = 16;
  localparam int WIN_B = 255;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sig1 = 1'b0;
  logic sig2 = 1'b1;
  logic sig3 = 1'b0;

  logic [7:0] tog1_a, tog2_a, wid_a, tog1_b, tog2_b, wid_b;
  logic [3:0] err_a, err_b;
  logic       done_a, pass_a, done_b, pass_b;

  int n_cmp = 0;
  int n_bad = 0;

  bit s1 [NS];
  bit s2 [NS];
  bit s3 [NS];

  always #5 clk = ~clk;

  wave_protocol_checker #(.WINDOW(WIN_A)) dut_a (
    .clk(clk), .rst(rst), .sig1(sig1), .sig2(sig2), .sig3(sig3),
    .tog1_cnt(tog1_a), .tog2_cnt(tog2_a), .sig3_width(wid_a),
    .err(err_a), .done(done_a), .pass(pass_a)
  );

  wave_protocol_checker #(.WINDOW(WIN_B)) dut_b (
    .clk(clk), .rst(rst), .sig1(sig1), .sig2(sig2), .sig3(sig3),
    .tog1_cnt(tog1_b), .tog2_cnt(tog2_b), .sig3_width(wid_b),
    .err(err_b), .done(done_b), .pass(pass_b)
  );

  task automatic check_val(input string tag, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic int pack(input int t1, input int t2, input int w,
                              input int e, input int d, input int p);
    return (t1 << 22) | (t2 << 14) | (w << 6) | (e << 2) | (d << 1) | p;
  endfunction

  function automatic int obs_a();
    return pack(int'(tog1_a), int'(tog2_a), int'(wid_a), int'(err_a),
                int'(done_a), int'(pass_a));
  endfunction

  function automatic int obs_b();
    return pack(int'(tog1_b), int'(tog2_b), int'(wid_b), int'(err_b),
                int'(done_b), int'(pass_b));
  endfunction

  // Expected verdict for a window of w samples after the arming sample s*[0]
  function automatic int model(input int w);
    int t1 = 0, t2 = 0, wid = 0, pulses = 0, e = 0;
    for (int k = 1; k <= w; k++) begin
      if (s1[k] != s1[k-1]) t1++;
      if (s2[k] != s2[k-1]) t2++;
      if (s3[k] && !s3[k-1]) pulses++;
      if (s3[k] && pulses <= 1) wid++;
    end
    if (t1 > 255) t1 = 255;
    if (t2 > 255) t2 = 255;
    if (wid > 255) wid = 255;
    if (s1[0] != 1'b0 || s2[0] != 1'b1 || s3[0] != 1'b0) e |= 1;
    if (t1 != 10) e |= 2;
    if (t2 != 10) e |= 4;
    if (pulses != 1 || wid < 2 || wid > 5 || s3[w]) e |= 8;
    return pack(t1, t2, wid, e, 1, (e == 0) ? 1 : 0);
  endfunction

  // Nominal generator sequence, then the per-mode fault or randomization
  task automatic build(input int mode);
    for (int k = 0; k < NS; k++) begin
      int kk = (k > 11) ? 11 : k;
      s1[k] = (k < 2) ? 1'b0 : bit'((kk - 1) & 1);
      s2[k] = ~s1[k];
      s3[k] = (k >= 4 && k <= 7);
    end
    case (mode)
      1: s2[0] = 1'b0;
      2: for (int k = 0; k < NS; k++) begin
           int kk = (k > 10) ? 10 : k;
           s1[k] = (k < 2) ? 1'b0 : bit'((kk - 1) & 1);
         end
      3: for (int k = 0; k < NS; k++) s3[k] = (k == 4 || k == 5 || k == 9 || k == 10);
      4: for (int k = 0; k < NS; k++) s3[k] = (k >= 4 && k <= 10);
      5: for (int k = 0; k < NS; k++) s3[k] = (k >= 14 && k <= 20);
      6: for (int k = 0; k < NS; k++) s1[k] = bit'(k & 1);
      7: begin
           if ($urandom_range(7) == 0) s1[0] = 1'b1;
           if ($urandom_range(7) == 0) s3[0] = 1'b1;
           for (int k = 1; k < NS; k++) begin
             if ($urandom_range(15) == 0) s1[k] = ~s1[k];
             if ($urandom_range(15) == 0) s2[k] = ~s2[k];
             if ($urandom_range(3) == 0)  s3[k] = ~s3[k];
           end
         end
      default: ;
    endcase
  endtask

  task automatic run_test(input int t, input int mode, input int pre_cycles);
    int exp_a, exp_b;
    build(mode);
    exp_a = model(WIN_A);
    exp_b = model(WIN_B);
    // Optional partial run with random inputs before the reset under test
    rst = 1'b0;
    for (int i = 0; i < pre_cycles; i++) begin
      sig1 = 1'($urandom); sig2 = 1'($urandom); sig3 = 1'($urandom);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    sig1 = 1'($urandom); sig2 = 1'($urandom); sig3 = 1'($urandom);
    @(posedge clk); #1;
    check_val($sformatf("t%0d_rst_a", t), obs_a(), 0);
    check_val($sformatf("t%0d_rst_b", t), obs_b(), 0);
    rst = 1'b0;
    for (int k = 0; k <= WIN_B + 2; k++) begin
      sig1 = s1[k]; sig2 = s2[k]; sig3 = s3[k];
      @(posedge clk); #1;
      if (k == WIN_A)     check_val($sformatf("t%0d_a_done_early", t), int'(done_a), 0);
      if (k == WIN_A + 1) check_val($sformatf("t%0d_a_result", t), obs_a(), exp_a);
      if (k == WIN_B)     check_val($sformatf("t%0d_b_done_early", t), int'(done_b), 0);
      if (k == WIN_B + 1) check_val($sformatf("t%0d_b_result", t), obs_b(), exp_b);
    end
    check_val($sformatf("t%0d_a_frozen", t), obs_a(), exp_a);
  endtask

  initial begin
    for (int m = 0; m <= 6; m++) run_test(m, m, 0);
    run_test(7, 0, 7);
    run_test(8, 0, 30);
    for (int t = 9; t < 29; t++) begin
      run_test(t, 7, ($urandom_range(1) == 0) ? 0 : int'($urandom_range(40, 1)));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
